// File: rtl/latency_issuer_pkg.sv
// Shared definitions for the latency job issuer.
//   state_e  : issuer FSM encoding (IDLE/ISSUE/WAIT/REPORT)
//   sat_add  : saturating add of a small increment, used by the error counter
package latency_issuer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      REPORT = 2'd3
   } state_e;

   // Adds inc (0..3) to val and clamps at max_val. The 33-bit sum keeps
   // the comparison correct even when max_val is 32'hFFFF_FFFF.
   function automatic logic [31:0] sat_add(input logic [31:0] val,
                                           input logic [1:0]  inc,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, val} + {31'd0, inc};
      return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
   endfunction

endpackage

// File: rtl/lat_timer.sv
// Latency counter for the job issuer.
// Cleared to 0 by clr_i, counts up by one per cycle while en_i is high.
// cnt_next_o is the value the counter moves to this cycle (cnt+1), which is
// the latency reported when done arrives; tc_o flags that cnt+1 has reached
// TIMEOUT.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clr_i        clear counter to 0 (priority over en_i)
//   en_i         count enable
//   cnt_next_o   current count + 1
//   tc_o         current count + 1 == TIMEOUT
module lat_timer #(
   parameter int CNT_WIDTH = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   output logic [CNT_WIDTH-1:0] cnt_next_o,
   output logic                 tc_o
);

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_W = CNT_WIDTH'(TIMEOUT);

   logic [CNT_WIDTH-1:0] cnt_q;

   assign cnt_next_o = cnt_q + 1'b1;
   assign tc_o       = (cnt_next_o == TIMEOUT_W);

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         cnt_q <= '0;
      end else if (en_i) begin
         cnt_q <= cnt_next_o;
      end
   end

endmodule

// File: rtl/latency_job_issuer.sv
// Initiator for the start/busy/done job protocol of a fixed-latency unit.
// Accepts one job at a time, pulses start, measures cycles until done,
// flags timeout / expected-latency mismatch and returns a response record.
//
// Handshakes (req_*, rsp_*): a transfer happens on a rising clk edge where
// valid and ready are both high. The issuer holds rsp_valid and all rsp_*
// fields stable until rsp_ready; req_ready never depends on req_valid.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake, req_expect = expected latency (0 = no check)
//   start           one-cycle start pulse to the unit
//   busy            unit busy; a new request is only accepted while low
//   done            unit completion pulse
//   rsp_valid/ready response handshake
//   rsp_latency     measured latency (TIMEOUT when abandoned)
//   rsp_timeout     job abandoned after TIMEOUT cycles
//   rsp_mismatch    latency differs from a non-zero expectation, or timeout
//   err_count       saturating count of mismatching responses and spurious dones
//   lat_min/lat_max min/max latency of non-timeout responses (LAT_STATS_EN only)
//   dbg_state       current FSM state
//
// Build option: define LAT_STATS_EN to add the lat_min/lat_max outputs.
module latency_job_issuer
   import latency_issuer_pkg::*;
#(
   parameter int CNT_WIDTH = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [CNT_WIDTH-1:0] req_expect,
   output logic                 start,
   input  logic                 busy,
   input  logic                 done,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CNT_WIDTH-1:0] rsp_latency,
   output logic                 rsp_timeout,
   output logic                 rsp_mismatch,
   output logic [CNT_WIDTH-1:0] err_count,
`ifdef LAT_STATS_EN
   output logic [CNT_WIDTH-1:0] lat_min,
   output logic [CNT_WIDTH-1:0] lat_max,
`endif
   output state_e               dbg_state
);

   localparam logic [31:0] ERR_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] expect_q;
   logic [CNT_WIDTH-1:0] rsp_latency_q;
   logic                 rsp_timeout_q;
   logic                 rsp_mismatch_q;
   logic                 mismatch_d;
   logic [CNT_WIDTH-1:0] err_q, err_d;

   logic                 tmr_clr, tmr_en;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 tmr_tc;

   logic                 accept;
   logic                 wait_exit;
   logic                 rsp_fire;
   logic                 spurious_done;
   logic                 rsp_err;

   lat_timer #(
      .CNT_WIDTH (CNT_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (tmr_clr),
      .en_i       (tmr_en),
      .cnt_next_o (cnt_next),
      .tc_o       (tmr_tc)
   );

   assign accept    = req_valid && req_ready;
   // done takes precedence over timeout when both land in the same cycle.
   assign wait_exit = (state_q == WAIT) && (done || tmr_tc);
   assign rsp_fire  = (state_q == REPORT) && rsp_ready;
   // Only done inside WAIT completes a job; anywhere else it is stale or stray.
   assign spurious_done = done && (state_q != WAIT);
   assign rsp_err       = rsp_fire && rsp_mismatch_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = ISSUE;
         ISSUE:                  state_d = WAIT;
         WAIT:    if (wait_exit) state_d = REPORT;
         REPORT:  if (rsp_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // rst gates req_ready and start combinationally so both drop in the
   // reset cycle itself rather than one cycle later.
   always_comb begin
      req_ready = (state_q == IDLE) && !busy && !rst;
      start     = (state_q == ISSUE) && !rst;
      rsp_valid = (state_q == REPORT);
      tmr_clr   = (state_q == ISSUE);
      tmr_en    = (state_q == WAIT);
   end

   assign dbg_state = state_q;

   // ---------------- response record and error counter ----------------
   assign mismatch_d = !done || ((expect_q != '0) && (cnt_next != expect_q));

   always_comb begin
      err_d = CNT_WIDTH'(sat_add(32'(err_q),
                                 {1'b0, spurious_done} + {1'b0, rsp_err},
                                 ERR_MAX));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         expect_q       <= '0;
         rsp_latency_q  <= '0;
         rsp_timeout_q  <= 1'b0;
         rsp_mismatch_q <= 1'b0;
         err_q          <= '0;
      end else begin
         if (accept) begin
            expect_q <= req_expect;
         end
         // On timeout cnt_next equals TIMEOUT, so one assignment covers both exits.
         if (wait_exit) begin
            rsp_latency_q  <= cnt_next;
            rsp_timeout_q  <= !done;
            rsp_mismatch_q <= mismatch_d;
         end
         err_q <= err_d;
      end
   end

   assign rsp_latency  = rsp_latency_q;
   assign rsp_timeout  = rsp_timeout_q;
   assign rsp_mismatch = rsp_mismatch_q;
   assign err_count    = err_q;

`ifdef LAT_STATS_EN
   logic [CNT_WIDTH-1:0] lat_min_q, lat_max_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lat_min_q <= '1;
         lat_max_q <= '0;
      end else if (rsp_fire && !rsp_timeout_q) begin
         if (rsp_latency_q < lat_min_q) lat_min_q <= rsp_latency_q;
         if (rsp_latency_q > lat_max_q) lat_max_q <= rsp_latency_q;
      end
   end

   assign lat_min = lat_min_q;
   assign lat_max = lat_max_q;
`endif

endmodule

// File: tb/tb_latency_job_issuer.sv
// Directed bench for latency_job_issuer.
// Instance a (TIMEOUT=64) drives a 4-cycle fixed-latency pipe model.
// Instance b (TIMEOUT=10) sees a stub unit whose done is driven by hand.
// sel routes the shared request/response stimulus to one instance and
// selects which instance the o_* observation signals show.
module tb_latency_job_issuer;
   import latency_issuer_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, sel, req_valid, rsp_ready, done_stub;
   logic [W-1:0] req_expect;

   logic         req_ready_a, start_a, rsp_valid_a, rsp_timeout_a, rsp_mismatch_a;
   logic [W-1:0] rsp_latency_a, err_count_a;
   state_e       state_a;
   logic         req_ready_b, start_b, rsp_valid_b, rsp_timeout_b, rsp_mismatch_b;
   logic [W-1:0] rsp_latency_b, err_count_b;
   state_e       state_b;
`ifdef LAT_STATS_EN
   logic [W-1:0] lat_min_a, lat_max_a, lat_min_b, lat_max_b;
`endif

   // 4-cycle pipe: done is high in the 4th cycle after the start cycle.
   logic [3:0] pipe_sr;
   logic       busy_a, done_a;
   always @(posedge clk) begin
      if (rst) pipe_sr <= '0;
      else     pipe_sr <= {pipe_sr[2:0], start_a};
   end
   assign busy_a = |pipe_sr;
   assign done_a = pipe_sr[3];

   logic req_valid_a, req_valid_b, rsp_ready_a, rsp_ready_b;
   assign req_valid_a = req_valid && !sel;
   assign req_valid_b = req_valid && sel;
   assign rsp_ready_a = rsp_ready && !sel;
   assign rsp_ready_b = rsp_ready && sel;

   logic         o_req_ready, o_start, o_rsp_valid, o_rsp_timeout, o_rsp_mismatch;
   logic [W-1:0] o_rsp_latency, o_err_count;
   state_e       o_state;
   assign o_req_ready    = sel ? req_ready_b    : req_ready_a;
   assign o_start        = sel ? start_b        : start_a;
   assign o_rsp_valid    = sel ? rsp_valid_b    : rsp_valid_a;
   assign o_rsp_timeout  = sel ? rsp_timeout_b  : rsp_timeout_a;
   assign o_rsp_mismatch = sel ? rsp_mismatch_b : rsp_mismatch_a;
   assign o_rsp_latency  = sel ? rsp_latency_b  : rsp_latency_a;
   assign o_err_count    = sel ? err_count_b    : err_count_a;
   assign o_state        = sel ? state_b        : state_a;

   latency_job_issuer #(.CNT_WIDTH(W), .TIMEOUT(64)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_expect(req_expect),
      .start(start_a), .busy(busy_a), .done(done_a),
      .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
      .rsp_latency(rsp_latency_a), .rsp_timeout(rsp_timeout_a),
      .rsp_mismatch(rsp_mismatch_a), .err_count(err_count_a),
`ifdef LAT_STATS_EN
      .lat_min(lat_min_a), .lat_max(lat_max_a),
`endif
      .dbg_state(state_a)
   );

   latency_job_issuer #(.CNT_WIDTH(W), .TIMEOUT(10)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_expect(req_expect),
      .start(start_b), .busy(1'b0), .done(done_stub),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
      .rsp_latency(rsp_latency_b), .rsp_timeout(rsp_timeout_b),
      .rsp_mismatch(rsp_mismatch_b), .err_count(err_count_b),
`ifdef LAT_STATS_EN
      .lat_min(lat_min_b), .lat_max(lat_max_b),
`endif
      .dbg_state(state_b)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns at the negedge of the ISSUE cycle.
   task automatic send_req(input logic [W-1:0] e);
      int n;
      req_expect = e;
      req_valid  = 1'b1;
      n = 0;
      while (!o_req_ready && n < 20) begin
         tick();
         n++;
      end
      check("req_accept", {31'd0, o_req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   // Returns at the negedge of the first REPORT cycle.
   task automatic wait_rsp();
      int n;
      n = 0;
      while (!o_rsp_valid && n < 40) begin
         tick();
         n++;
      end
      check("rsp_arrives", {31'd0, o_rsp_valid}, 32'd1);
   endtask

   task automatic rsp_handshake();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, nstart, nrsp, st[3];
      logic drop, saw_rsp;

      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      done_stub = 1'b0; req_expect = '0;
      tick(); tick();

      // Reset state
      check("rst_req_ready", {31'd0, req_ready_a}, 32'd0);
      check("rst_start",     {31'd0, start_a}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
      check("rst_err",       32'(err_count_a), 32'd0);
      check("rst_latency",   32'(rsp_latency_a), 32'd0);
      check("rst_state",     32'(state_a), 32'(IDLE));
      check("rst_err_b",     32'(err_count_b), 32'd0);
`ifdef LAT_STATS_EN
      check("rst_lat_min", 32'(lat_min_a), 32'hFF);
      check("rst_lat_max", 32'(lat_max_a), 32'd0);
`endif
      rst = 1'b0;
      tick();
      check("post_rst_req_ready", {31'd0, req_ready_a}, 32'd1);

      // 1: matching expectation
      send_req(8'd4);
      check("t1_start_high", {31'd0, o_start}, 32'd1);
      tick();
      check("t1_start_low", {31'd0, o_start}, 32'd0);
      wait_rsp();
      check("t1_latency",  32'(o_rsp_latency), 32'd4);
      check("t1_mismatch", {31'd0, o_rsp_mismatch}, 32'd0);
      check("t1_timeout",  {31'd0, o_rsp_timeout}, 32'd0);
      check("t1_err",      32'(o_err_count), 32'd0);
      rsp_handshake();
      check("t1_idle",      32'(o_state), 32'(IDLE));
      check("t1_rsp_clear", {31'd0, o_rsp_valid}, 32'd0);

      // 2: three back-to-back jobs, rsp_ready held high
      rsp_ready = 1'b1; req_valid = 1'b1; req_expect = 8'd4;
      acc = 0; drop = 1'b0; nstart = 0; nrsp = 0;
      st[0] = 0; st[1] = 0; st[2] = 0;
      for (int i = 0; i < 40; i++) begin
         if (drop) req_valid = 1'b0;
         if (o_start) begin
            if (nstart < 3) st[nstart] = cyc;
            nstart++;
         end
         if (o_rsp_valid) begin
            check("t2_latency", 32'(o_rsp_latency), 32'd4);
            nrsp++;
         end
         if (req_valid && o_req_ready) begin
            acc++;
            if (acc == 3) drop = 1'b1;
         end
         tick();
      end
      rsp_ready = 1'b0; req_valid = 1'b0;
      check("t2_starts",    32'(nstart), 32'd3);
      check("t2_responses", 32'(nrsp), 32'd3);
      check("t2_gap_1",     32'(st[1] - st[0]), 32'd7);
      check("t2_gap_2",     32'(st[2] - st[1]), 32'd7);

      // 3: expectation mismatch
      send_req(8'd5);
      wait_rsp();
      check("t3_latency",  32'(o_rsp_latency), 32'd4);
      check("t3_mismatch", {31'd0, o_rsp_mismatch}, 32'd1);
      check("t3_timeout",  {31'd0, o_rsp_timeout}, 32'd0);
      rsp_handshake();
      check("t3_err", 32'(o_err_count), 32'd1);

      // 4: unit never answers (instance b, TIMEOUT=10)
      sel = 1'b1;
      send_req(8'd0);
      wait_rsp();
      check("t4_timeout",  {31'd0, o_rsp_timeout}, 32'd1);
      check("t4_latency",  32'(o_rsp_latency), 32'd10);
      check("t4_mismatch", {31'd0, o_rsp_mismatch}, 32'd1);
      rsp_handshake();
      check("t4_err", 32'(o_err_count), 32'd1);
      done_stub = 1'b1; tick(); done_stub = 1'b0; tick();
      check("t4_late_done_err", 32'(o_err_count), 32'd2);

      // done in the ISSUE cycle is stale, not a completion
      send_req(8'd0);
      done_stub = 1'b1; tick(); done_stub = 1'b0;
      check("t4_issue_done_err", 32'(o_err_count), 32'd3);
      wait_rsp();
      check("t4_issue_done_timeout", {31'd0, o_rsp_timeout}, 32'd1);
      check("t4_issue_done_latency", 32'(o_rsp_latency), 32'd10);
      // mismatching response and a spurious done in the same cycle add 2
      rsp_ready = 1'b1; done_stub = 1'b1; tick();
      rsp_ready = 1'b0; done_stub = 1'b0;
      check("t4_double_err", 32'(o_err_count), 32'd5);
      check("t4_idle", 32'(o_state), 32'(IDLE));
      sel = 1'b0;

      // 5: response back-pressure
      send_req(8'd4);
      wait_rsp();
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("t5_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
         check("t5_latency",   32'(o_rsp_latency), 32'd4);
         check("t5_mismatch",  {31'd0, o_rsp_mismatch}, 32'd0);
         check("t5_req_ready", {31'd0, o_req_ready}, 32'd0);
         check("t5_no_start",  {31'd0, o_start}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1; tick();
      check("t5_idle_after_release", 32'(o_state), 32'(IDLE));
      req_valid = 1'b0; rsp_ready = 1'b0;
      tick();
      check("t5_stays_idle", 32'(o_state), 32'(IDLE));
      check("t5_err", 32'(o_err_count), 32'd1);

      // 6: reset two cycles into WAIT
      send_req(8'd4);
      tick(); tick();
      check("t6_in_wait", 32'(o_state), 32'(WAIT));
      rst = 1'b1;
      tick();
      check("t6_state",     32'(o_state), 32'(IDLE));
      check("t6_start",     {31'd0, o_start}, 32'd0);
      check("t6_req_ready", {31'd0, o_req_ready}, 32'd0);
      check("t6_err_clear", 32'(o_err_count), 32'd0);
      rst = 1'b0;
      saw_rsp = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (o_rsp_valid) saw_rsp = 1'b1;
         tick();
      end
      check("t6_no_response", {31'd0, saw_rsp}, 32'd0);
      send_req(8'd4);
      wait_rsp();
      check("t6_latency",  32'(o_rsp_latency), 32'd4);
      check("t6_mismatch", {31'd0, o_rsp_mismatch}, 32'd0);
      rsp_handshake();
      check("t6_err", 32'(o_err_count), 32'd0);
`ifdef LAT_STATS_EN
      check("t6_lat_min", 32'(lat_min_a), 32'd4);
      check("t6_lat_max", 32'(lat_max_a), 32'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
